r4_frac_div_ctrl: RTL and testbench

R4_FRAC_DIV_CTRL -- requirements
Module: r4_frac_div_ctrl

---
 rtl/fpdiv_r4_pkg.sv | 40 ++++
 rtl/r4_otf_conv.sv | 57 +++++
 rtl/r4_frac_div_ctrl.sv | 120 ++++++++++++
 tb/tb_r4_frac_div_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fpdiv_r4_pkg.sv
// Shared FSM states, one-hot quotient digit constants and the on-the-fly conversion digit encoder
// for the radix-4 fractional divider controller.
package fpdiv_r4_pkg;

  typedef enum logic [4:0] {
    IDLE = 5'b00001,
    PRE  = 5'b00010,
    ITER = 5'b00100,
    POST = 5'b01000,
    DONE = 5'b10000
  } fsm_state_t;

  localparam logic [4:0] QUO_DIG_NEG_2 = 5'b10000;
  localparam logic [4:0] QUO_DIG_NEG_1 = 5'b01000;
  localparam logic [4:0] QUO_DIG_ZERO  = 5'b00100;
  localparam logic [4:0] QUO_DIG_POS_1 = 5'b00010;
  localparam logic [4:0] QUO_DIG_POS_2 = 5'b00001;

  // Source register and appended bits for the next Q and QM.
  typedef struct packed {
    logic       q_from_qm;
    logic [1:0] q_lsb;
    logic       qm_from_q;
    logic [1:0] qm_lsb;
  } ofc_dig_t;

  function automatic ofc_dig_t ofc_dig_enc(input logic [4:0] dig);
    ofc_dig_t enc;
    enc = '{q_from_qm: 1'b0, q_lsb: 2'd0, qm_from_q: 1'b0, qm_lsb: 2'd3};
    case (dig)
      QUO_DIG_POS_2: enc = '{q_from_qm: 1'b0, q_lsb: 2'd2, qm_from_q: 1'b1, qm_lsb: 2'd1};
      QUO_DIG_POS_1: enc = '{q_from_qm: 1'b0, q_lsb: 2'd1, qm_from_q: 1'b1, qm_lsb: 2'd0};
      QUO_DIG_NEG_1: enc = '{q_from_qm: 1'b1, q_lsb: 2'd3, qm_from_q: 1'b0, qm_lsb: 2'd2};
      QUO_DIG_NEG_2: enc = '{q_from_qm: 1'b1, q_lsb: 2'd2, qm_from_q: 1'b0, qm_lsb: 2'd1};
      default: ;
    endcase
    return enc;
  endfunction

endpackage

// File: rtl/r4_otf_conv.sv
// On-the-fly conversion of radix-4 signed digits into Q and QM (= Q - 1 ulp), one digit per update.
// Early finish shifts the partial Q into final position and rebuilds QM from it.
module r4_otf_conv
  import fpdiv_r4_pkg::*;
#(
  parameter int QUO_W = 26,
  parameter int SH_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             init_i,
  input  logic             upd_i,
  input  logic [4:0]       dig_i,
  input  logic             early_i,
  input  logic [SH_W-1:0]  shamt_i,
  output logic [QUO_W-1:0] q_o,
  output logic [QUO_W-1:0] qm_o
);

  ofc_dig_t         enc;
  logic [QUO_W-1:0] q_src;
  logic [QUO_W-1:0] qm_src;
  logic [QUO_W-1:0] q_nrm;
  logic [QUO_W-1:0] qm_nrm;
  logic [QUO_W-1:0] q_nxt;
  logic [QUO_W-1:0] qm_nxt;

  always_comb begin
    enc    = ofc_dig_enc(dig_i);
    q_src  = enc.q_from_qm ? qm_o : q_o;
    qm_src = enc.qm_from_q ? q_o : qm_o;
    q_nrm  = {q_src[QUO_W-3:0], enc.q_lsb};
    qm_nrm = {qm_src[QUO_W-3:0], enc.qm_lsb};
    q_nxt  = q_nrm;
    qm_nxt = qm_nrm;
    // Remaining digits are all zero: their effect is a plain left shift of Q.
    if (early_i) begin
      q_nxt  = q_nrm << shamt_i;
      qm_nxt = q_nxt - QUO_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      q_o  <= '0;
      qm_o <= '0;
    end else if (init_i) begin
      q_o  <= '0;
      qm_o <= '1;
    end else if (upd_i) begin
      q_o  <= q_nxt;
      qm_o <= qm_nxt;
    end
  end

endmodule

// File: rtl/r4_frac_div_ctrl.sv
// Radix-4 divider control: IDLE/PRE/ITER/POST/DONE, result valid QUO_W/2+3 cycles after start, held until finish_ready_i.
// Build option FDIV_R4_EARLY_FINISH_EN ends iteration as soon as the partial remainder is zero.
module r4_frac_div_ctrl
  import fpdiv_r4_pkg::*;
#(
  parameter int QUO_W = 26
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid_i,
  output logic             start_ready_o,
  input  logic             flush_i,
  input  logic [4:0]       qds_quo_dig_i,
  input  logic             rem_zero_i,
  input  logic             rem_sign_i,
  output logic             rem_init_en_o,
  output logic             rem_update_en_o,
  output logic [4:0]       prev_quo_dig_o,
  output logic             finish_valid_o,
  input  logic             finish_ready_i,
  output logic [QUO_W-1:0] quo_o
);

  localparam int ITER_N = QUO_W / 2;
  localparam int CNT_W  = $clog2(ITER_N);

  fsm_state_t       state;
  fsm_state_t       state_nxt;
  logic [CNT_W-1:0] iter_cnt;
  logic [4:0]       dig_sel;
  logic             early_fin;
  logic [QUO_W-1:0] q;
  logic [QUO_W-1:0] qm;

  assign dig_sel = $onehot(qds_quo_dig_i) ? qds_quo_dig_i : QUO_DIG_ZERO;

`ifdef FDIV_R4_EARLY_FINISH_EN
  assign early_fin = (state == ITER) && rem_zero_i && (iter_cnt != '0);
`else
  logic unused_rem_zero;
  assign unused_rem_zero = rem_zero_i;
  assign early_fin       = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt       = state;
    start_ready_o   = 1'b0;
    rem_init_en_o   = 1'b0;
    rem_update_en_o = 1'b0;
    finish_valid_o  = 1'b0;
    case (state)
      IDLE: begin
        start_ready_o = 1'b1;
        if (start_valid_i) state_nxt = PRE;
      end
      PRE: begin
        rem_init_en_o = 1'b1;
        state_nxt     = ITER;
      end
      ITER: begin
        rem_update_en_o = 1'b1;
        if (iter_cnt == '0 || early_fin) state_nxt = POST;
      end
      POST: state_nxt = DONE;
      DONE: begin
        finish_valid_o = 1'b1;
        if (finish_ready_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (flush_i) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      iter_cnt       <= '0;
      prev_quo_dig_o <= QUO_DIG_ZERO;
      quo_o          <= '0;
    end else begin
      case (state)
        PRE: begin
          iter_cnt       <= CNT_W'(ITER_N - 1);
          prev_quo_dig_o <= QUO_DIG_ZERO;
        end
        ITER: begin
          prev_quo_dig_o <= dig_sel;
          if (early_fin)             iter_cnt <= '0;
          else if (iter_cnt != '0)   iter_cnt <= iter_cnt - CNT_W'(1);
        end
        POST: quo_o <= rem_sign_i ? qm : q;
        default: ;
      endcase
    end
  end

  r4_otf_conv #(
    .QUO_W (QUO_W),
    .SH_W  (CNT_W + 1)
  ) u_otf (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (flush_i),
    .init_i  (rem_init_en_o),
    .upd_i   (rem_update_en_o),
    .dig_i   (dig_sel),
    .early_i (early_fin),
    .shamt_i ({iter_cnt, 1'b0}),
    .q_o     (q),
    .qm_o    (qm)
  );

  a_dig_onehot: assert property (@(posedge clk) disable iff (rst || flush_i)
    (state == ITER) |-> $onehot(qds_quo_dig_i));

endmodule

// File: tb/tb_r4_frac_div_ctrl.sv
// Scoreboard bench for r4_frac_div_ctrl: directed digit sequences, expected quotients computed by hand.
module tb_r4_frac_div_ctrl;

  localparam int QUO_W  = 26;
  localparam int ITER_N = QUO_W / 2;
  localparam int LAT    = ITER_N + 3;
`ifdef FDIV_R4_EARLY_FINISH_EN
  localparam int EF_ITERS = 2;
`else
  localparam int EF_ITERS = ITER_N;
`endif

  localparam logic [4:0] D_N2 = 5'b10000;
  localparam logic [4:0] D_N1 = 5'b01000;
  localparam logic [4:0] D_Z  = 5'b00100;
  localparam logic [4:0] D_P1 = 5'b00010;
  localparam logic [4:0] D_P2 = 5'b00001;

  logic             clk = 1'b0;
  logic             rst;
  logic             start_valid_i;
  logic             start_ready_o;
  logic             flush_i;
  logic [4:0]       qds_quo_dig_i;
  logic             rem_zero_i;
  logic             rem_sign_i;
  logic             rem_init_en_o;
  logic             rem_update_en_o;
  logic [4:0]       prev_quo_dig_o;
  logic             finish_valid_o;
  logic             finish_ready_i;
  logic [QUO_W-1:0] quo_o;

  r4_frac_div_ctrl #(.QUO_W(QUO_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .start_valid_i   (start_valid_i),
    .start_ready_o   (start_ready_o),
    .flush_i         (flush_i),
    .qds_quo_dig_i   (qds_quo_dig_i),
    .rem_zero_i      (rem_zero_i),
    .rem_sign_i      (rem_sign_i),
    .rem_init_en_o   (rem_init_en_o),
    .rem_update_en_o (rem_update_en_o),
    .prev_quo_dig_o  (prev_quo_dig_o),
    .finish_valid_o  (finish_valid_o),
    .finish_ready_i  (finish_ready_i),
    .quo_o           (quo_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [QUO_W-1:0] quo;
    int               start;
    int               lat;
    int               iters;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   upd_cnt = 0;
  bit   vld_seen = 0;
  bit   saw_fin;
  logic [ITER_N-1:0][4:0] digs;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: latency and iteration count on valid rise, quotient on the finish handshake.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      vld_seen = 0;
      upd_cnt  = 0;
    end else begin
      if (rem_init_en_o) upd_cnt = 0;
      if (rem_update_en_o) upd_cnt++;
      if (finish_valid_o && !vld_seen) begin
        vld_seen = 1;
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_finish: finish_valid_o with empty scoreboard, quo_o=0x%0h", quo_o);
        end else begin
          e = sb[0];
          check("latency", 32'(cyc - e.start), 32'(e.lat));
          check("iter_cycles", 32'(upd_cnt), 32'(e.iters));
        end
      end
      if (finish_valid_o && finish_ready_i) begin
        vld_seen = 0;
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("quo", 32'(quo_o), 32'(e.quo));
        end
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (!start_ready_o && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!start_ready_o) begin
      n_cmp++;
      n_err++;
      $display("FAIL idle_timeout: start_ready_o=%0b after %0d cycles, expected 1", start_ready_o, n);
    end
  endtask

  task automatic run_div(input logic [ITER_N-1:0][4:0] d, input logic sign, input int rz_idx,
                         input logic [QUO_W-1:0] exp_quo, input int exp_iters);
    exp_t e;
    wait_idle();
    start_valid_i = 1'b1;
    rem_sign_i    = sign;
    e.quo   = exp_quo;
    e.start = cyc;
    e.lat   = exp_iters + 3;
    e.iters = exp_iters;
    sb.push_back(e);
    @(posedge clk); #1;
    start_valid_i = 1'b0;
    check("pre_init_en", 32'(rem_init_en_o), 32'd1);
    for (int i = 0; i < ITER_N; i++) begin
      @(posedge clk); #1;
      qds_quo_dig_i = d[i];
      rem_zero_i    = (i == rz_idx);
    end
    @(posedge clk); #1;
    qds_quo_dig_i = D_Z;
    rem_zero_i    = 1'b0;
  endtask

  task automatic fill(input logic [4:0] v);
    for (int i = 0; i < ITER_N; i++) digs[i] = v;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    start_valid_i  = 1'b0;
    flush_i        = 1'b0;
    qds_quo_dig_i  = D_Z;
    rem_zero_i     = 1'b0;
    rem_sign_i     = 1'b0;
    finish_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_ctrl", 32'({start_ready_o, rem_init_en_o, rem_update_en_o, finish_valid_o, prev_quo_dig_o}),
          32'({1'b1, 3'b000, D_Z}));
    check("reset_quo", 32'(quo_o), 32'd0);

    fill(D_P1);
    run_div(digs, 1'b0, -1, 26'h1555555, ITER_N);

    fill(D_Z); digs[0] = D_P2; digs[1] = D_N1;
    run_div(digs, 1'b0, -1, 26'h1C00000, ITER_N);
    run_div(digs, 1'b1, -1, 26'h1BFFFFF, ITER_N);

    fill(D_N2);
    run_div(digs, 1'b0, -1, 26'h1555556, ITER_N);

    // Consumer stalls for 5 cycles in DONE.
    fill(D_P1);
    wait_idle();
    finish_ready_i = 1'b0;
    run_div(digs, 1'b1, -1, 26'h1555554, ITER_N);
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      check("stall_valid", 32'(finish_valid_o), 32'd1);
      check("stall_quo", 32'(quo_o), 32'h1555554);
      check("stall_start_ready", 32'(start_ready_o), 32'd0);
      @(posedge clk); #1;
    end
    finish_ready_i = 1'b1;
    check("stall_valid_last", 32'(finish_valid_o), 32'd1);
    @(posedge clk); #1;
    check("stall_idle_after_ready", 32'({start_ready_o, finish_valid_o}), 32'b10);

    // Flush on the 4th ITER cycle together with a start request.
    wait_idle();
    start_valid_i = 1'b1;
    @(posedge clk); #1;
    start_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      qds_quo_dig_i = D_P1;
      if (i == 3) begin
        flush_i       = 1'b1;
        start_valid_i = 1'b1;
      end
    end
    @(posedge clk); #1;
    flush_i       = 1'b0;
    start_valid_i = 1'b0;
    qds_quo_dig_i = D_Z;
    check("flush_ctrl", 32'({start_ready_o, rem_init_en_o, rem_update_en_o, finish_valid_o, prev_quo_dig_o}),
          32'({1'b1, 3'b000, D_Z}));
    check("flush_quo", 32'(quo_o), 32'd0);
    saw_fin = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (finish_valid_o) saw_fin = 1'b1;
    end
    check("flush_no_finish", 32'(saw_fin), 32'd0);

    // Reset in the middle of iteration, then a normal run.
    wait_idle();
    start_valid_i = 1'b1;
    @(posedge clk); #1;
    start_valid_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      qds_quo_dig_i = D_P2;
      if (i == 4) rst = 1'b1;
    end
    @(posedge clk); #1;
    rst = 1'b0;
    qds_quo_dig_i = D_Z;
    check("midrst_ctrl", 32'({start_ready_o, rem_init_en_o, rem_update_en_o, finish_valid_o, prev_quo_dig_o}),
          32'({1'b1, 3'b000, D_Z}));
    check("midrst_quo", 32'(quo_o), 32'd0);
    fill(D_P2);
    run_div(digs, 1'b0, -1, 26'h2AAAAAA, ITER_N);

    // Remainder goes to zero after two +1 digits.
    fill(D_Z); digs[0] = D_P1; digs[1] = D_P1;
    run_div(digs, 1'b0, 1, 26'h1400000, EF_ITERS);

    wait_idle();
    repeat (5) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
